// File: rtl/sme_bank_ldst_if.sv
// sme_bank_ldst_if: data memory request/response bus between the bank load/store sequencer and memory.
interface sme_bank_ldst_if #(parameter int XLEN = 32);
    logic            mem_req;
    logic            mem_gnt;
    logic            mem_wen;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_strb;
    logic            mem_recv;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_error;

    modport master (
        output mem_req, mem_wen, mem_addr, mem_wdata, mem_strb, mem_ack,
        input  mem_gnt, mem_recv, mem_rdata, mem_error
    );
    modport slave (
        input  mem_req, mem_wen, mem_addr, mem_wdata, mem_strb, mem_ack,
        output mem_gnt, mem_recv, mem_rdata, mem_error
    );
endinterface

// File: rtl/sme_bank_ldst.sv
// sme_bank_ldst: sequences SME bank loads (memory -> bank write port) and stores (bank data -> memory).
module sme_bank_ldst #(
    parameter int XLEN = 32,
    parameter int SMAX = 4
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic [XLEN-1:0] csr_smectl,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic            op_load,
    input  logic            op_store,
    input  logic [XLEN-1:0] op_addr,
    input  logic [3:0]      op_reg,
    input  logic [XLEN-1:0] op_sdata,
    output logic            op_done,
    output logic            op_error,
    sme_bank_ldst_if.master bus,
    output logic            bank_wen,
    output logic [3:0]      bank_waddr,
    output logic [XLEN-1:0] bank_wdata
);
    localparam int XL = XLEN - 1;

    typedef enum logic [1:0] {IDLE, REQ, RSP, WB} state_t;

    state_t        state;
    logic          killed, is_store, done_q, err_q;
    logic [XL-2:0] addr_q;
    logic [3:0]    reg_q;
    logic [XL:0]   sdata_q, rdata_q;
    logic [3:0]    b;
    logic          accept, bad, kill;
    logic          unused_ok;

    assign b         = csr_smectl[3:0];
    assign accept    = op_valid && op_ready;
    assign bad       = (|op_addr[1:0]) || (b == 4'd0) || (int'(b) >= SMAX);
    assign kill      = killed || flush;
    assign unused_ok = ^{op_load, csr_smectl[XL:4]};

    assign op_ready      = (state == IDLE) && !flush;
    assign op_done       = (done_q || state == WB) && !flush;
    assign op_error      = done_q && err_q && !flush;
    assign bus.mem_req   = (state == REQ);
    assign bus.mem_wen   = bus.mem_req && is_store;
    assign bus.mem_addr  = bus.mem_req ? {addr_q, 2'b00} : '0;
    assign bus.mem_wdata = bus.mem_wen ? sdata_q : '0;
    assign bus.mem_strb  = bus.mem_req ? 4'hF : 4'h0;
    assign bus.mem_ack   = 1'b1;
    assign bank_wen      = (state == WB) && !flush;
    assign bank_waddr    = bank_wen ? reg_q : 4'd0;
    assign bank_wdata    = bank_wen ? rdata_q : '0;

    // Killed transactions still finish on the bus but never report or write the bank.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state    <= IDLE;
            killed   <= 1'b0;
            is_store <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            reg_q    <= 4'd0;
            sdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    is_store <= op_store;
                    addr_q   <= op_addr[XL:2];
                    reg_q    <= op_reg;
                    sdata_q  <= op_sdata;
                    if (bad) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else state <= REQ;
                end
                REQ: begin
                    killed <= kill;
                    if (bus.mem_gnt) state <= RSP;
                end
                RSP: begin
                    killed <= kill;
                    if (bus.mem_recv) begin
                        rdata_q <= bus.mem_rdata;
                        if (is_store || bus.mem_error || kill) begin
                            state  <= IDLE;
                            killed <= 1'b0;
                            done_q <= !kill;
                            err_q  <= bus.mem_error;
                        end else state <= WB;
                    end
                end
                default: begin
                    state  <= IDLE;
                    killed <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sme_bank_ldst.sv
// tb_sme_bank_ldst: directed bench for the SME bank load/store sequencer.
module tb_sme_bank_ldst;
    logic        g_clk = 1'b0;
    logic        g_resetn, flush, op_valid, op_load, op_store;
    logic [31:0] csr_smectl, op_addr, op_sdata;
    logic [3:0]  op_reg;
    logic        op_ready, op_done, op_error, bank_wen;
    logic [3:0]  bank_waddr;
    logic [31:0] bank_wdata;
    int          errors = 0;
    int          checks = 0;

    sme_bank_ldst_if #(.XLEN(32)) bus();

    sme_bank_ldst #(.XLEN(32), .SMAX(4)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .csr_smectl(csr_smectl),
        .op_valid(op_valid), .op_ready(op_ready), .op_load(op_load), .op_store(op_store),
        .op_addr(op_addr), .op_reg(op_reg), .op_sdata(op_sdata), .op_done(op_done),
        .op_error(op_error), .bus(bus), .bank_wen(bank_wen), .bank_waddr(bank_waddr),
        .bank_wdata(bank_wdata)
    );

    always #5 g_clk = ~g_clk;

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic st, input logic [31:0] b, input logic [31:0] a,
                         input logic [3:0] r, input logic [31:0] sd);
        csr_smectl = b; op_valid = 1'b1; op_load = !st; op_store = st;
        op_addr = a; op_reg = r; op_sdata = sd;
        tick;
        op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; op_sdata = 32'h0;
    endtask

    initial begin
        g_resetn = 1'b0; flush = 1'b0; op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
        csr_smectl = 32'h0; op_addr = 32'h0; op_reg = 4'h0; op_sdata = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_recv = 1'b0; bus.mem_rdata = 32'h0; bus.mem_error = 1'b0;
        tick; tick;
        chk("rst_req", bus.mem_req, 0);
        chk("rst_done", op_done, 0);
        chk("rst_bwen", bank_wen, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_ack", bus.mem_ack, 1);
        g_resetn = 1'b1;
        tick;

        // load, bank 1, reg 5
        chk("ld_ready", op_ready, 1);
        offer(1'b0, 32'h1, 32'h100, 4'd5, 32'h0);
        chk("ld_req", bus.mem_req, 1);
        chk("ld_addr", bus.mem_addr, 32'h100);
        chk("ld_wen", bus.mem_wen, 0);
        chk("ld_strb", bus.mem_strb, 32'hF);
        bus.mem_gnt = 1'b1; tick; bus.mem_gnt = 1'b0;
        chk("ld_req_drop", bus.mem_req, 0);
        bus.mem_recv = 1'b1; bus.mem_rdata = 32'hDEADBEEF; tick; bus.mem_recv = 1'b0; bus.mem_rdata = 32'h0;
        chk("ld_bwen", bank_wen, 1);
        chk("ld_waddr", bank_waddr, 5);
        chk("ld_wdata", bank_wdata, 32'hDEADBEEF);
        chk("ld_done", op_done, 1);
        chk("ld_err", op_error, 0);
        tick;
        chk("ld_bwen_off", bank_wen, 0);
        chk("ld_wdata_off", bank_wdata, 0);
        chk("ld_done_off", op_done, 0);

        // store, bank 2, grant delayed 3 cycles
        offer(1'b1, 32'h2, 32'h204, 4'd0, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_gnt = 1'b1;
            chk("st_req", bus.mem_req, 1);
            chk("st_addr", bus.mem_addr, 32'h204);
            chk("st_wdata", bus.mem_wdata, 32'h12345678);
            chk("st_wen", bus.mem_wen, 1);
            chk("st_strb", bus.mem_strb, 32'hF);
            tick;
        end
        bus.mem_gnt = 1'b0;
        chk("st_req_drop", bus.mem_req, 0);
        chk("st_wdata_off", bus.mem_wdata, 0);
        bus.mem_recv = 1'b1;
        chk("st_done_early", op_done, 0);
        tick; bus.mem_recv = 1'b0;
        chk("st_done", op_done, 1);
        chk("st_err", op_error, 0);
        chk("st_bwen", bank_wen, 0);
        tick;
        chk("st_done_off", op_done, 0);

        // misaligned address, bank 0, bank >= SMAX
        offer(1'b0, 32'h1, 32'h102, 4'd1, 32'h0);
        chk("mis_done", op_done, 1);
        chk("mis_err", op_error, 1);
        chk("mis_req", bus.mem_req, 0);
        tick;
        chk("mis_done_off", op_done, 0);
        chk("mis_req2", bus.mem_req, 0);
        offer(1'b0, 32'h0, 32'h100, 4'd1, 32'h0);
        chk("b0_done", op_done, 1);
        chk("b0_err", op_error, 1);
        chk("b0_req", bus.mem_req, 0);
        tick;
        offer(1'b1, 32'h4, 32'h100, 4'd1, 32'h55);
        chk("b4_err", op_error, 1);
        chk("b4_req", bus.mem_req, 0);
        tick;

        // load with bus error
        offer(1'b0, 32'h1, 32'h10, 4'd2, 32'h0);
        bus.mem_gnt = 1'b1; tick; bus.mem_gnt = 1'b0;
        bus.mem_recv = 1'b1; bus.mem_error = 1'b1; tick; bus.mem_recv = 1'b0; bus.mem_error = 1'b0;
        chk("berr_done", op_done, 1);
        chk("berr_err", op_error, 1);
        chk("berr_bwen", bank_wen, 0);
        tick;
        chk("berr_bwen2", bank_wen, 0);
        chk("berr_done_off", op_done, 0);

        // flush in RSP on a load, then next op accepted in first IDLE cycle
        offer(1'b0, 32'h1, 32'h20, 4'd7, 32'h0);
        bus.mem_gnt = 1'b1; tick; bus.mem_gnt = 1'b0;
        flush = 1'b1; tick; flush = 1'b0;
        bus.mem_recv = 1'b1; bus.mem_rdata = 32'hAAAA5555; tick; bus.mem_recv = 1'b0;
        chk("fl_bwen", bank_wen, 0);
        chk("fl_done", op_done, 0);
        chk("fl_ready", op_ready, 1);
        offer(1'b1, 32'h3, 32'h30, 4'd0, 32'hCAFEF00D);
        chk("fl_next_req", bus.mem_req, 1);
        chk("fl_next_wdata", bus.mem_wdata, 32'hCAFEF00D);
        chk("fl_done2", op_done, 0);
        bus.mem_gnt = 1'b1; tick; bus.mem_gnt = 1'b0;
        bus.mem_recv = 1'b1; tick; bus.mem_recv = 1'b0;
        chk("fl_next_done", op_done, 1);
        tick;

        // bank select changes after accept are ignored
        offer(1'b0, 32'h1, 32'h40, 4'd3, 32'h0);
        csr_smectl = 32'h0;
        chk("cb_req", bus.mem_req, 1);
        bus.mem_gnt = 1'b1; tick; bus.mem_gnt = 1'b0;
        bus.mem_recv = 1'b1; bus.mem_rdata = 32'h0BADF00D; tick; bus.mem_recv = 1'b0;
        chk("cb_bwen", bank_wen, 1);
        chk("cb_waddr", bank_waddr, 3);
        chk("cb_wdata", bank_wdata, 32'h0BADF00D);
        chk("cb_err", op_error, 0);
        tick;

        // async reset in REQ clears request without a clock edge
        offer(1'b1, 32'h1, 32'h80, 4'd0, 32'h11112222);
        chk("ar_req_pre", bus.mem_req, 1);
        #2 g_resetn = 1'b0;
        #1;
        chk("ar_req", bus.mem_req, 0);
        chk("ar_addr", bus.mem_addr, 0);
        chk("ar_wdata", bus.mem_wdata, 0);
        tick; g_resetn = 1'b1; tick;

        // async reset in RSP, then a late response is ignored
        offer(1'b0, 32'h1, 32'h90, 4'd9, 32'h0);
        bus.mem_gnt = 1'b1; tick; bus.mem_gnt = 1'b0;
        #2 g_resetn = 1'b0;
        #1;
        chk("ar2_req", bus.mem_req, 0);
        chk("ar2_done", op_done, 0);
        chk("ar2_bwen", bank_wen, 0);
        tick; g_resetn = 1'b1;
        bus.mem_recv = 1'b1; bus.mem_rdata = 32'h99999999; tick; bus.mem_recv = 1'b0;
        chk("late_bwen", bank_wen, 0);
        chk("late_done", op_done, 0);
        tick;
        chk("late_bwen2", bank_wen, 0);
        chk("late_done2", op_done, 0);
        chk("late_ready", op_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
